if_id_reg: RTL

Pipeline register between the instruction-fetch stage and the decode stage of the five-stage MIPS core with precise exceptions. It captures the fetched instruction, its PC, the fetch-address exception and the branch-delay-slot flag. It holds on stall and flushes on exception entry. It squashes the wrong-path instruction behind an `eret`, tracking whether the redirect has already happened during a stall.

---
 rtl/cpu_defs.sv | 15 +
 rtl/pc_adel_chk.sv | 13 +
 rtl/if_id_reg.sv | 89 ++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared constants for the five-stage MIPS core: address map, exception codes, nop.
package cpu_defs;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] PC_HANDLER = 32'h0000_4180;

  localparam logic [31:0] IM_LO = 32'h0000_3000;
  localparam logic [31:0] IM_HI = 32'h0000_6ffc;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/pc_adel_chk.sv
// Instruction-address error check: misaligned or outside instruction memory.
module pc_adel_chk
  import cpu_defs::*;
(
  input  logic [31:0] pc,
  output logic        adel
);

  always_comb begin
    adel = (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall hold, exception flush and post-eret squash.
module if_id_reg #(
  parameter logic [31:0] PC_RESET   = cpu_defs::PC_RESET,
  parameter logic [31:0] PC_HANDLER = cpu_defs::PC_HANDLER
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_Instr,
  input  logic        ID_BranchJump,
  input  logic        npc_stall,
  input  logic        Req,
  input  logic        ID_eret,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_Instr,
  output logic [4:0]  ID_ExcCode,
  output logic        ID_BD,
  output logic        ID_valid
);

  logic [31:0] pc_d, pc_q;
  logic [31:0] instr_d, instr_q;
  logic [4:0]  exc_d, exc_q;
  logic        bd_d, bd_q;
  logic        valid_d, valid_q;
  logic        eret_redir_d, eret_redir_q;
  logic        if_adel;

  pc_adel_chk u_pc_adel_chk (
    .pc   (IF_PC),
    .adel (if_adel)
  );

  always_comb begin
    pc_d         = pc_q;
    instr_d      = instr_q;
    exc_d        = exc_q;
    bd_d         = bd_q;
    valid_d      = valid_q;
    eret_redir_d = 1'b0;
    if (Req) begin
      pc_d    = PC_HANDLER;
      instr_d = cpu_defs::NOP;
      exc_d   = cpu_defs::EXC_NONE;
      bd_d    = 1'b0;
      valid_d = 1'b0;
    end else if (npc_stall) begin
      // Fetch has already been redirected to EPC while eret waits in ID.
      eret_redir_d = eret_redir_q | ID_eret;
    end else if (ID_eret && !eret_redir_q) begin
      pc_d    = IF_PC;
      instr_d = cpu_defs::NOP;
      exc_d   = cpu_defs::EXC_NONE;
      bd_d    = 1'b0;
      valid_d = 1'b0;
    end else begin
      pc_d    = IF_PC;
      instr_d = if_adel ? cpu_defs::NOP : IF_Instr;
      exc_d   = if_adel ? cpu_defs::EXC_ADEL : cpu_defs::EXC_NONE;
      bd_d    = ID_BranchJump;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      pc_q         <= PC_RESET;
      instr_q      <= cpu_defs::NOP;
      exc_q        <= cpu_defs::EXC_NONE;
      bd_q         <= 1'b0;
      valid_q      <= 1'b0;
      eret_redir_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      exc_q        <= exc_d;
      bd_q         <= bd_d;
      valid_q      <= valid_d;
      eret_redir_q <= eret_redir_d;
    end
  end

  assign ID_PC      = pc_q;
  assign ID_Instr   = instr_q;
  assign ID_ExcCode = exc_q;
  assign ID_BD      = bd_q;
  assign ID_valid   = valid_q;

endmodule
